frame_buffers_ring_controller: RTL

//  Parametrised successor to the ping-pong swap controller: manages NUM_BUFFERS frame buffers
//  (2 = double, 3+ = triple/multi buffering). It hands the rasteriser a target buffer, queues

---
 rtl/frame_buffers_ring_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/frame_buffers_ring_controller.sv
// Multi-buffer frame controller: hands the rasteriser a target buffer, queues finished
// frames in order and promotes the oldest one to scan-out once per swap window.
module frame_buffers_ring_controller #(
    parameter int unsigned  NUM_BUFFERS = 3,
    localparam int unsigned IDX_W       = (NUM_BUFFERS > 2) ? $clog2(NUM_BUFFERS) : 1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_raster_in_progress,
    input  logic             i_frame_buffer_swap_allowed,
    input  logic             i_drop_mode,
    output logic             o_new_frame,
    output logic [IDX_W-1:0] o_rasterization_target,
    output logic [IDX_W-1:0] o_display_source,
    output logic [IDX_W:0]   o_pending_count,
    output logic             o_swap,
    output logic             o_frame_dropped
);

    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned PEND_D = (NUM_BUFFERS > 2) ? NUM_BUFFERS - 2 : 1;

    localparam logic [1:0] ST_FRAME_READY        = 2'd0;
    localparam logic [1:0] ST_RASTER_IN_PROGRESS = 2'd1;
    localparam logic [1:0] ST_FRAME_FINISHED     = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       target_q, target_d;
    logic [IDX_W-1:0]       display_q, display_d;
    logic [IDX_W-1:0]       pend_q [PEND_D];
    logic [IDX_W-1:0]       pend_d [PEND_D];
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_BUFFERS-1:0] free_q, free_d;
    logic                   armed_q, armed_d;
    logic                   new_frame_q, new_frame_d;
    logic                   swap_q, swap_d;
    logic                   dropped_q, dropped_d;

    logic                   swap_perm;
    logic                   disp_swap;
    logic                   free_any;
    logic [IDX_W-1:0]       low_free;
    logic                   alloc;
    logic                   push;
    logic                   pop_drop;
    logic                   pp_swap;
    logic                   pop;
    logic [CNT_W-1:0]       wr_idx;

    // Lowest-index free buffer for the next rasteriser target.
    always_comb begin
        low_free = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (free_q[i]) low_free = IDX_W'(i);
        end
    end

    assign free_any  = |free_q;
    assign swap_perm = i_frame_buffer_swap_allowed && armed_q;
    assign disp_swap = swap_perm && (cnt_q != '0);

    // Next-state logic: FSM, display promotion, pending FIFO and free pool.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        display_d   = display_q;
        free_d      = free_q;
        armed_d     = armed_q;
        dropped_d   = 1'b0;
        alloc       = 1'b0;
        push        = 1'b0;
        pop_drop    = 1'b0;
        pp_swap     = 1'b0;

        case (state_q)
            ST_FRAME_READY: begin
                if (i_raster_in_progress) state_d = ST_RASTER_IN_PROGRESS;
            end
            ST_RASTER_IN_PROGRESS: begin
                if (!i_raster_in_progress) state_d = ST_FRAME_FINISHED;
            end
            ST_FRAME_FINISHED: begin
                if (free_any) begin
                    alloc    = 1'b1;
                    push     = 1'b1;
                    target_d = low_free;
                    state_d  = ST_FRAME_READY;
                end else if ((cnt_q != '0) && i_drop_mode && !disp_swap) begin
                    // Recycle the oldest pending frame as the new target.
                    pop_drop  = 1'b1;
                    push      = 1'b1;
                    target_d  = pend_q[0];
                    dropped_d = 1'b1;
                    state_d   = ST_FRAME_READY;
                end else if ((cnt_q == '0) && swap_perm) begin
                    pp_swap   = 1'b1;
                    display_d = target_q;
                    target_d  = display_q;
                    state_d   = ST_FRAME_READY;
                end
            end
            default: state_d = ST_FRAME_READY;
        endcase

        if (disp_swap) display_d = pend_q[0];

        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (alloc && (low_free == IDX_W'(i))) free_d[i] = 1'b0;
            if (disp_swap && (display_q == IDX_W'(i))) free_d[i] = 1'b1;
        end

        pop    = disp_swap || pop_drop;
        wr_idx = cnt_q - CNT_W'(pop);
        for (int i = 0; i < PEND_D; i++) begin
            pend_d[i] = pop ? pend_q[(i + 1 < PEND_D) ? i + 1 : i] : pend_q[i];
            if (push && (CNT_W'(i) == wr_idx)) pend_d[i] = target_q;
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (!i_frame_buffer_swap_allowed) armed_d = 1'b1;
        else if (disp_swap || pp_swap)    armed_d = 1'b0;

        swap_d      = disp_swap || pp_swap;
        new_frame_d = (state_d == ST_FRAME_READY);
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q     <= ST_FRAME_READY;
            target_q    <= '0;
            display_q   <= IDX_W'(1);
            cnt_q       <= '0;
            armed_q     <= 1'b1;
            new_frame_q <= 1'b1;
            swap_q      <= 1'b0;
            dropped_q   <= 1'b0;
            for (int i = 0; i < NUM_BUFFERS; i++) free_q[i] <= (i >= 2);
            for (int i = 0; i < PEND_D; i++) pend_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            display_q   <= display_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            new_frame_q <= new_frame_d;
            swap_q      <= swap_d;
            dropped_q   <= dropped_d;
            free_q      <= free_d;
            for (int i = 0; i < PEND_D; i++) pend_q[i] <= pend_d[i];
        end
    end

    assign o_new_frame            = new_frame_q;
    assign o_rasterization_target = target_q;
    assign o_display_source       = display_q;
    assign o_pending_count        = cnt_q;
    assign o_swap                 = swap_q;
    assign o_frame_dropped        = dropped_q;

endmodule
